// File: rtl/mips_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_fetch_pkg
//  Description : Shared definitions for the MIPS instruction-fetch sequencer:
//                state encodings and default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_fetch_pkg;

  // Default widths (PC counts in words)
  localparam int DEFAULT_ADDR_WIDTH  = 16;
  localparam int DEFAULT_INSTR_WIDTH = 32;

  // State encodings, 3 bits
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_LOAD  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_HOLD  = ST_HOLD,
    S_DRAIN = ST_DRAIN,
    S_LOAD  = ST_LOAD
  } fetch_state_e;

endpackage : mips_fetch_pkg
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer. Drives the PC register's load
//                and increment strobes, runs the instruction-memory req/ack
//                handshake and presents fetched instructions to decode over
//                valid/ready. Branch/jump redirects flush any fetch in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  pc_in_i,
  output logic                   pc_load_o,
  output logic                   pc_inc_o,
  output logic [ADDR_WIDTH-1:0]  pc_next_o,
  output logic                   imem_req_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic                   imem_ack_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   instr_valid_o,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o,
  input  logic                   instr_ready_i,
  input  logic                   redirect_valid_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_target_i
);

  fetch_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]  target_q, target_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  instr_pc_q, instr_pc_d;
  logic                   first_q, first_d;

  // State and datapath registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      first_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      first_q    <= first_d;
    end
  end

  // Next-state logic and Moore output decode from state and registers only
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    first_d       = 1'b0;
    pc_load_o     = 1'b0;
    pc_inc_o      = 1'b0;
    pc_next_o     = '0;
    imem_req_o    = 1'b0;
    imem_addr_o   = '0;
    instr_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        // No PC strobe is active here, so pc_in is a stable address
        imem_req_o  = 1'b1;
        imem_addr_o = pc_in_i;
        if (imem_ack_i) begin
          if (redirect_valid_i) begin
            target_d = redirect_target_i;
            state_d  = S_LOAD;
          end else begin
            instr_d    = imem_rdata_i;
            instr_pc_d = pc_in_i;
            first_d    = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid_i) begin
          target_d = redirect_target_i;
          state_d  = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // Keep the request up until its ack; returned data is discarded
        imem_req_o  = 1'b1;
        imem_addr_o = pc_in_i;
        if (redirect_valid_i) target_d = redirect_target_i;
        if (imem_ack_i) state_d = S_LOAD;
      end

      S_HOLD: begin
        instr_valid_o = 1'b1;
        pc_inc_o      = first_q;
        if (redirect_valid_i) begin
          target_d = redirect_target_i;
          state_d  = S_LOAD;
        end else if (instr_ready_i) begin
          state_d = S_FETCH;
        end
      end

      S_LOAD: begin
        pc_load_o = 1'b1;
        pc_next_o = target_q;
        // A further redirect retargets and repeats the load
        if (redirect_valid_i) begin
          target_d = redirect_target_i;
          state_d  = S_LOAD;
        end else begin
          state_d = S_FETCH;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign instr_o    = instr_q;
  assign instr_pc_o = instr_pc_q;

endmodule : fetch_ctrl
`default_nettype wire
